// File: rtl/mem_axi_bridge.sv
// Bridges the core's memory command/data/response channels onto one AXI HP port.
// Each command is one 8-beat x 64-bit burst; reads are paired into 128-bit responses.
module mem_axi_bridge #(
    parameter logic [3:0]  ADDR_BASE  = 4'h1,
    parameter int unsigned MAX_WR_OUT = 4
) (
    input  logic         host_clk,
    input  logic         reset,

    input  logic         mem_req_cmd_valid,
    output logic         mem_req_cmd_ready,
    input  logic [25:0]  mem_req_cmd_addr,
    input  logic [4:0]   mem_req_cmd_tag,
    input  logic         mem_req_cmd_rw,

    input  logic         mem_req_data_valid,
    output logic         mem_req_data_ready,
    input  logic [127:0] mem_req_data_bits,

    output logic         mem_resp_valid,
    input  logic         mem_resp_ready,
    output logic [127:0] mem_resp_data,
    output logic [4:0]   mem_resp_tag,

    output logic         axi_awvalid,
    input  logic         axi_awready,
    output logic [31:0]  axi_awaddr,
    output logic [5:0]   axi_awid,

    output logic         axi_wvalid,
    input  logic         axi_wready,
    output logic [63:0]  axi_wdata,
    output logic         axi_wlast,
    input  logic         axi_bvalid,
    output logic         axi_bready,

    output logic         axi_arvalid,
    input  logic         axi_arready,
    output logic [31:0]  axi_araddr,
    output logic [5:0]   axi_arid,
    input  logic         axi_rvalid,
    output logic         axi_rready,
    input  logic [63:0]  axi_rdata,
    input  logic [5:0]   axi_rid,
    input  logic         axi_rlast
);

    localparam logic [3:0] MaxWrOut = 4'(MAX_WR_OUT);

    typedef enum logic [1:0] {StIdle, StRdAddr, StWrAddr, StWrData} state_e;

    state_e      state_q;
    logic [2:0]  beat_q;
    logic [3:0]  wr_out_q;
    logic        half_q;
    logic [63:0] buffer_q;

    logic st_rd, st_wa, st_wd;
    logic aw_hs, w_hs, b_dec;
    logic unused_bits;

    // Outputs are gated by reset so nothing leaks out before the first reset edge.
    assign st_rd = (state_q == StRdAddr) && !reset;
    assign st_wa = (state_q == StWrAddr) && !reset;
    assign st_wd = (state_q == StWrData) && !reset;

    assign axi_araddr  = {ADDR_BASE, mem_req_cmd_addr[21:0], 6'b0};
    assign axi_awaddr  = {ADDR_BASE, mem_req_cmd_addr[21:0], 6'b0};
    assign axi_arid    = {1'b0, mem_req_cmd_tag};
    assign axi_awid    = 6'd0;
    assign axi_arvalid = st_rd;
    assign axi_awvalid = st_wa;
    assign mem_req_cmd_ready = (st_rd && axi_arready) || (st_wa && axi_awready);

    assign axi_wvalid  = st_wd && mem_req_data_valid;
    assign axi_wdata   = beat_q[0] ? mem_req_data_bits[127:64] : mem_req_data_bits[63:0];
    assign axi_wlast   = st_wd && (beat_q == 3'd7);
    assign mem_req_data_ready = st_wd && beat_q[0] && axi_wready;
    assign axi_bready  = 1'b1;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    // A B response with nothing outstanding is ignored unless it pairs with a new AW.
    assign b_dec = axi_bvalid && ((wr_out_q != 4'd0) || aw_hs);

    // Read path: first beat of each pair is buffered, second beat passes straight through.
    assign axi_rready     = reset || !half_q || mem_resp_ready;
    assign mem_resp_valid = !reset && half_q && axi_rvalid;
    assign mem_resp_data  = {axi_rdata, buffer_q};
    assign mem_resp_tag   = axi_rid[4:0];

    assign unused_bits = ^{mem_req_cmd_addr[25:22], axi_rid[5], axi_rlast};

    always_ff @(posedge host_clk) begin
        if (reset) begin
            state_q  <= StIdle;
            beat_q   <= 3'd0;
            wr_out_q <= 4'd0;
            half_q   <= 1'b0;
            buffer_q <= 64'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_req_cmd_valid && !mem_req_cmd_rw) begin
                        state_q <= StRdAddr;
                    end else if (mem_req_cmd_valid && mem_req_cmd_rw && mem_req_data_valid &&
                                 (wr_out_q < MaxWrOut)) begin
                        state_q <= StWrAddr;
                    end
                end
                StRdAddr: if (axi_arready) state_q <= StIdle;
                StWrAddr: if (axi_awready) state_q <= StWrData;
                StWrData: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd7) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (aw_hs && !b_dec && (wr_out_q < MaxWrOut)) begin
                wr_out_q <= wr_out_q + 4'd1;
            end else if (b_dec && !aw_hs) begin
                wr_out_q <= wr_out_q - 4'd1;
            end

            if (!half_q && axi_rvalid) begin
                buffer_q <= axi_rdata;
                half_q   <= 1'b1;
            end else if (half_q && axi_rvalid && mem_resp_ready) begin
                half_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Self-checking bench for mem_axi_bridge: bench acts as both the core and the AXI slave.
module tb_mem_axi_bridge;

    logic         host_clk = 1'b0;
    logic         reset;
    logic         mem_req_cmd_valid, mem_req_cmd_ready, mem_req_cmd_rw;
    logic [25:0]  mem_req_cmd_addr;
    logic [4:0]   mem_req_cmd_tag;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic         mem_resp_valid, mem_resp_ready;
    logic [127:0] mem_resp_data;
    logic [4:0]   mem_resp_tag;
    logic         axi_awvalid, axi_awready;
    logic [31:0]  axi_awaddr;
    logic [5:0]   axi_awid;
    logic         axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;
    logic [63:0]  axi_wdata;
    logic         axi_arvalid, axi_arready;
    logic [31:0]  axi_araddr;
    logic [5:0]   axi_arid;
    logic         axi_rvalid, axi_rready, axi_rlast;
    logic [63:0]  axi_rdata;
    logic [5:0]   axi_rid;

    int n_checks = 0;
    int n_pass   = 0;
    int out_cnt  = 0;

    always #5 host_clk = ~host_clk;

    mem_axi_bridge dut (
        .host_clk           (host_clk),
        .reset              (reset),
        .mem_req_cmd_valid  (mem_req_cmd_valid),
        .mem_req_cmd_ready  (mem_req_cmd_ready),
        .mem_req_cmd_addr   (mem_req_cmd_addr),
        .mem_req_cmd_tag    (mem_req_cmd_tag),
        .mem_req_cmd_rw     (mem_req_cmd_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_ready     (mem_resp_ready),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag),
        .axi_awvalid        (axi_awvalid),
        .axi_awready        (axi_awready),
        .axi_awaddr         (axi_awaddr),
        .axi_awid           (axi_awid),
        .axi_wvalid         (axi_wvalid),
        .axi_wready         (axi_wready),
        .axi_wdata          (axi_wdata),
        .axi_wlast          (axi_wlast),
        .axi_bvalid         (axi_bvalid),
        .axi_bready         (axi_bready),
        .axi_arvalid        (axi_arvalid),
        .axi_arready        (axi_arready),
        .axi_araddr         (axi_araddr),
        .axi_arid           (axi_arid),
        .axi_rvalid         (axi_rvalid),
        .axi_rready         (axi_rready),
        .axi_rdata          (axi_rdata),
        .axi_rid            (axi_rid),
        .axi_rlast          (axi_rlast)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge host_clk);
        #1;
    endtask

    function automatic logic [31:0] axi_addr(input logic [25:0] a);
        return 32'h1000_0000 + 32'(a % 26'h40_0000) * 32'd64;
    endfunction

    task automatic b_resp();
        axi_bvalid = 1'b1;
        #1 check("bready", axi_bready, 1'b1);
        step();
        axi_bvalid = 1'b0;
        if (out_cnt > 0) out_cnt--;
    endtask

    task automatic aw_blocked(input int n);
        for (int i = 0; i < n; i++) begin
            #1 check("aw_withheld", axi_awvalid, 1'b0);
            check("aw_withheld_cmd_ready", mem_req_cmd_ready, 1'b0);
            step();
        end
    endtask

    task automatic issue_read(input logic [25:0] addr, input logic [4:0] tag, input int dly);
        bit done = 0;
        mem_req_cmd_valid = 1'b1; mem_req_cmd_rw = 1'b0;
        mem_req_cmd_addr = addr; mem_req_cmd_tag = tag;
        for (int t = 0; t < 6; t++) begin
            axi_arready = (t > dly);
            #1;
            if (axi_arvalid) begin
                check("araddr", axi_araddr, axi_addr(addr));
                check("arid", axi_arid, {1'b0, tag});
                check("rd_cmd_ready", mem_req_cmd_ready, axi_arready);
                if (axi_arready) begin
                    step();
                    done = 1;
                    break;
                end
            end
            step();
        end
        check("ar_handshake", done, 1'b1);
        mem_req_cmd_valid = 1'b0; axi_arready = 1'b0;
        #1 check("arvalid_after", axi_arvalid, 1'b0);
    endtask

    // Drives 8 R beats; the core must see 4 responses built from beat pairs {odd, even}.
    task automatic read_burst(input logic [4:0] tag, input int stall, input bit seq, input bit gaps);
        logic [63:0]  beat [8];
        logic [127:0] exp;
        for (int i = 0; i < 8; i++) beat[i] = seq ? 64'(i) : {$urandom, $urandom};
        axi_rid = {1'b0, tag};
        for (int k = 0; k < 4; k++) begin
            exp = {beat[2*k+1], beat[2*k]};
            if (gaps && $urandom_range(0, 1) == 1) begin
                axi_rvalid = 1'b0;
                #1 check("gap_resp_valid", mem_resp_valid, 1'b0);
                step();
            end
            axi_rvalid = 1'b1; axi_rdata = beat[2*k]; mem_resp_ready = 1'($urandom);
            #1 check("first_rready", axi_rready, 1'b1);
            check("first_resp_valid", mem_resp_valid, 1'b0);
            step();
            axi_rdata = beat[2*k+1]; mem_resp_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                #1 check("stall_rready", axi_rready, 1'b0);
                check("stall_resp_valid", mem_resp_valid, 1'b1);
                check("stall_resp_data", mem_resp_data, exp);
                step();
            end
            mem_resp_ready = 1'b1;
            #1 check("resp_rready", axi_rready, 1'b1);
            check("resp_valid", mem_resp_valid, 1'b1);
            check("resp_data", mem_resp_data, exp);
            check("resp_tag", mem_resp_tag, tag);
            step();
        end
        axi_rvalid = 1'b0; mem_resp_ready = 1'b0;
        #1 check("resp_valid_idle", mem_resp_valid, 1'b0);
    endtask

    // Full write burst; reset_at >= 0 pulses reset after that many W handshakes.
    task automatic do_write(input logic [25:0] addr, input bit toggle, input bit b_at_aw,
                            input int reset_at);
        logic [127:0] words [4];
        logic [63:0]  exp;
        bit done = 0;
        bit phase = 0;
        for (int i = 0; i < 4; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_req_cmd_valid = 1'b1; mem_req_cmd_rw = 1'b1; mem_req_cmd_addr = addr;
        mem_req_cmd_tag = 5'($urandom); mem_req_data_valid = 1'b1;
        mem_req_data_bits = words[0]; axi_awready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (axi_awvalid) begin
                check("awaddr", axi_awaddr, axi_addr(addr));
                check("awid", axi_awid, 6'd0);
                check("wr_cmd_ready", mem_req_cmd_ready, 1'b1);
                axi_bvalid = b_at_aw;
                step();
                axi_bvalid = 1'b0;
                done = 1;
                break;
            end
            step();
        end
        check("aw_handshake", done, 1'b1);
        mem_req_cmd_valid = 1'b0; axi_awready = 1'b0;
        if (!done) return;
        if (!b_at_aw) out_cnt++;
        for (int b = 0; b < 8; b++) begin
            if (b == reset_at) begin
                reset = 1'b1;
                step();
                #1 check("rst_wvalid", axi_wvalid, 1'b0);
                check("rst_awvalid", axi_awvalid, 1'b0);
                check("rst_data_ready", mem_req_data_ready, 1'b0);
                reset = 1'b0;
                #1 check("post_rst_wvalid", axi_wvalid, 1'b0);
                check("post_rst_awvalid", axi_awvalid, 1'b0);
                mem_req_data_valid = 1'b0;
                out_cnt = 0;
                step();
                return;
            end
            mem_req_data_bits = words[b/2];
            exp = (b % 2 == 0) ? words[b/2][63:0] : words[b/2][127:64];
            done = 0;
            for (int t = 0; t < 4; t++) begin
                axi_wready = toggle ? phase : 1'b1;
                phase = ~phase;
                #1 check("wvalid", axi_wvalid, 1'b1);
                check("wdata", axi_wdata, exp);
                check("wlast", axi_wlast, b == 7);
                check("data_ready", mem_req_data_ready, axi_wready && (b % 2 == 1));
                step();
                if (axi_wready) begin
                    done = 1;
                    break;
                end
            end
            check("w_handshake", done, 1'b1);
        end
        axi_wready = 1'b0; mem_req_data_valid = 1'b0;
        #1 check("wvalid_after", axi_wvalid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        mem_req_cmd_valid = 1'b1; mem_req_cmd_rw = 1'b0; mem_req_cmd_addr = '0;
        mem_req_cmd_tag = '0; mem_req_data_valid = 1'b1; mem_req_data_bits = '0;
        mem_resp_ready = 1'b0; axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b0;
        axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = '0; axi_rid = '0; axi_rlast = 1'b0;
        step();
        step();
        check("rst_arvalid", axi_arvalid, 1'b0);
        check("rst_awvalid0", axi_awvalid, 1'b0);
        check("rst_wvalid0", axi_wvalid, 1'b0);
        check("rst_resp_valid", mem_resp_valid, 1'b0);
        check("rst_cmd_ready", mem_req_cmd_ready, 1'b0);
        check("rst_data_ready0", mem_req_data_ready, 1'b0);
        check("rst_wlast", axi_wlast, 1'b0);
        check("rst_bready", axi_bready, 1'b1);
        check("rst_rready", axi_rready, 1'b1);
        mem_req_cmd_valid = 1'b0; mem_req_data_valid = 1'b0; axi_awready = 1'b0;
        axi_wready = 1'b0; axi_arready = 1'b0; axi_rvalid = 1'b0;
        reset = 1'b0;
        step();

        // Directed read: araddr 100048C0, beats 0..7 -> {1,0},{3,2},{5,4},{7,6}
        issue_read(26'h000123, 5'd5, 0);
        check("dir_araddr_const", axi_addr(26'h000123), 32'h1000_48C0);
        read_burst(5'd5, 0, 1'b1, 1'b0);

        // Directed write to top of window, then back-pressured response
        do_write(26'h03F_FFFF, 1'b0, 1'b0, -1);
        b_resp();
        issue_read(26'h2AB_CDEF, 5'd17, 2);
        read_burst(5'd17, 3, 1'b0, 1'b0);

        // wready toggling every cycle
        do_write(26'($urandom), 1'b1, 1'b0, -1);
        b_resp();

        // Outstanding-write limit
        for (int i = 0; i < 4; i++) do_write(26'($urandom), 1'b0, 1'b0, -1);
        mem_req_cmd_valid = 1'b1; mem_req_cmd_rw = 1'b1; mem_req_data_valid = 1'b1;
        aw_blocked(3);
        b_resp();
        do_write(26'($urandom), 1'b0, 1'b1, -1);
        do_write(26'($urandom), 1'b0, 1'b0, -1);
        mem_req_cmd_valid = 1'b1; mem_req_cmd_rw = 1'b1; mem_req_data_valid = 1'b1;
        aw_blocked(3);
        mem_req_cmd_valid = 1'b0; mem_req_data_valid = 1'b0;
        repeat (4) b_resp();

        // Randomized mix
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [4:0] tg;
                tg = 5'($urandom);
                issue_read(26'($urandom), tg, $urandom_range(0, 2));
                read_burst(tg, $urandom_range(0, 2), 1'b0, 1'b1);
            end else begin
                do_write(26'($urandom), 1'($urandom), 1'b0, -1);
                b_resp();
            end
        end

        // Reset in the middle of a write burst, then a normal read
        do_write(26'($urandom), 1'b0, 1'b0, 3);
        issue_read(26'h0000040, 5'd9, 1);
        read_burst(5'd9, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_axi_bridge.md
MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 4'h1, meaning the AXI address bits [31:28] prepended to every request.
REQ-002 SHALL have parameter MAX_WR_OUT, default 4, meaning the maximum number of write bursts awaiting a B response (range 1-15).
REQ-003 SHALL have port host_clk  in  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports mem_req_cmd_valid in 1, mem_req_cmd_ready out 1, mem_req_cmd_addr in 26, mem_req_cmd_tag in 5, mem_req_cmd_rw in 1 (1 = write): the core's command channel.
REQ-006 SHALL have ports mem_req_data_valid in 1, mem_req_data_ready out 1, mem_req_data_bits in 128: the core's write-data channel.
REQ-007 SHALL have ports mem_resp_valid out 1, mem_resp_ready in 1, mem_resp_data out 128, mem_resp_tag out 5: the core's read-response channel.
REQ-008 SHALL have ports axi_awvalid out 1, axi_awready in 1, axi_awaddr out 32, axi_awid out 6: the AXI write-address channel to the HP port.
REQ-009 SHALL have ports axi_wvalid out 1, axi_wready in 1, axi_wdata out 64, axi_wlast out 1, axi_bvalid in 1, axi_bready out 1: the AXI write-data and write-response channels.
REQ-010 SHALL have ports axi_arvalid out 1, axi_arready in 1, axi_araddr out 32, axi_arid out 6, axi_rvalid in 1, axi_rready out 1, axi_rdata in 64, axi_rid in 6, axi_rlast in 1: the AXI read channels.
REQ-011 SHALL NOT drive burst attributes; len 7, size 3'b011, INCR and strobe 8'hff are tied off by the integrator, so each command is one 8-beat x 64-bit burst.

Function
REQ-012 SHALL form both axi_awaddr and axi_araddr as {ADDR_BASE, mem_req_cmd_addr[21:0], 6'b0}.
REQ-013 SHALL implement an FSM with states IDLE, RD_ADDR, WR_ADDR and WR_DATA.
REQ-014 SHALL, in IDLE, go to RD_ADDR when cmd_valid && !rw.
REQ-015 SHALL, in IDLE, go to WR_ADDR when cmd_valid && rw && data_valid && wr_out < MAX_WR_OUT.
REQ-016 SHALL otherwise hold IDLE.
REQ-017 SHALL assert axi_arvalid only in RD_ADDR, with axi_arid = {1'b0, cmd_tag}, and return to IDLE on arready.
REQ-018 SHALL assert axi_awvalid only in WR_ADDR, with axi_awid = 6'd0, and go to WR_DATA on awready.
REQ-019 SHALL drive mem_req_cmd_ready combinationally as (RD_ADDR && arready) || (WR_ADDR && awready).
REQ-020 SHALL, in WR_DATA, drive axi_wvalid = mem_req_data_valid and axi_wdata = beat[0] ? bits[127:64] : bits[63:0], where beat is a 3-bit counter.
REQ-021 SHALL advance beat on each wvalid && wready, and assert axi_wlast only when beat == 7.
REQ-022 SHALL drive mem_req_data_ready = WR_DATA && beat[0] && wready, giving exactly 4 data handshakes per burst.
REQ-023 SHALL, on the beat-7 handshake, go to IDLE with beat wrapping to 0.
REQ-024 SHALL keep wr_out as a 4-bit count: +1 on the aw handshake, -1 on bvalid, unchanged when both occur in the same cycle, never exceeding MAX_WR_OUT and never underflowing.
REQ-025 SHALL tie axi_bready to 1.
REQ-026 SHALL run the read-data path independently of the FSM, so reads drain while writes issue.
REQ-027 SHALL use a half flag on the read-data path: with half = 0, axi_rready = 1, and an rvalid captures rdata into a 64-bit buffer and sets half.
REQ-028 SHALL, with half = 1, drive axi_rready = mem_resp_ready, mem_resp_valid = rvalid, mem_resp_data = {axi_rdata, buffer} and mem_resp_tag = axi_rid[4:0], and clear half on the handshake.
REQ-029 SHALL add zero latency from the second beat to the response, hold rdata unconsumed while mem_resp_ready = 0, and lose no beat.
REQ-030 SHALL ignore axi_rlast for sequencing.

Reset
REQ-031 SHALL, on reset, set FSM = IDLE, beat = 0, half = 0, wr_out = 0 and buffer = 0.
REQ-032 SHALL drive these output values while reset is asserted: all valids = 0, cmd_ready = 0, data_ready = 0, wlast = 0, bready = 1, rready = 1.
REQ-033 SHALL abandon any partial burst on reset mid-operation; the AXI side is reset together with this block.

Verification
REQ-034 SHALL pass: read with addr 26'h000123, tag 5 -> araddr 32'h100048C0, arid 6'h05; 8 R beats with rdata = 0..7 and rid 5 -> 4 responses {1,0}, {3,2}, {5,4}, {7,6}, each with tag 5.
REQ-035 SHALL pass: write with addr[21:0] = 22'h3FFFFF and 4 data words -> awaddr 32'h1FFFFFC0, 8 W beats, wlast only on beat 7, data_ready pulses on beats 1, 3, 5, 7.
REQ-036 SHALL pass: mem_resp_ready = 0 for 3 cycles during the second beat -> rready = 0 and data stable; response delivered once ready = 1.
REQ-037 SHALL pass: bvalid held 0 while 5 writes are issued with MAX_WR_OUT = 4 -> the 5th awvalid is withheld until one bvalid; aw and b handshakes in the same cycle -> wr_out unchanged.
REQ-038 SHALL pass: wready toggling every cycle -> wdata and wvalid held until accepted, and no data word is skipped.
REQ-039 SHALL pass: reset asserted at write beat 3 -> next cycle wvalid = 0 and awvalid = 0; a following read completes normally.
